// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - ISA opcodes, instruction field positions and fetch FSM state
// shared by the front end and the control unit.
package core_pkg;

  localparam int WORD_W   = 16;
  localparam int OPC_W    = 7;
  localparam int REG_W    = 3;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 9;
  localparam int RDST_MSB = 8;
  localparam int RDST_LSB = 6;
  localparam int RSRC_MSB = 5;
  localparam int RSRC_LSB = 3;

  localparam logic [OPC_W-1:0] OPC_NOP  = 7'b0000000;
  localparam logic [OPC_W-1:0] OPC_ADD  = 7'b0000101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 7'b0000110;
  localparam logic [OPC_W-1:0] OPC_AND  = 7'b0000111;
  localparam logic [OPC_W-1:0] OPC_OR   = 7'b0001000;
  localparam logic [OPC_W-1:0] OPC_MOV  = 7'b0001101;
  localparam logic [OPC_W-1:0] OPC_IADD = 7'b0100000;
  localparam logic [OPC_W-1:0] OPC_LDD  = 7'b0100010;
  localparam logic [OPC_W-1:0] OPC_LDR  = 7'b0110000;
  localparam logic [OPC_W-1:0] OPC_LDM  = 7'b0110101;
  localparam logic [OPC_W-1:0] OPC_STR  = 7'b0111000;
  localparam logic [OPC_W-1:0] OPC_JMP  = 7'b1000000;
  localparam logic [OPC_W-1:0] OPC_HLT  = 7'b1100001;

  typedef enum logic [1:0] {
    FETCH1,
    FETCH2,
    ISSUE,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rdst;
    logic [REG_W-1:0] rsrc;
  } instr_fields_t;

  // Opcodes whose second word is a 16-bit immediate.
  function automatic logic is_two_word(input logic [OPC_W-1:0] opc);
    return (opc == OPC_IADD) || (opc == OPC_LDM) || (opc == OPC_LDD);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory, redirect and issue signals
// of the fetch unit; master is the fetch unit, slave is memory/execute/control.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 20
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [6:0]        opcode;
  logic [2:0]        rdst;
  logic [2:0]        rsrc;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] instr_pc;
  logic              halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  flush, flush_pc,
    output instr_valid,
    input  instr_ready,
    output opcode, rdst, rsrc, imm, instr_pc, halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output flush, flush_pc,
    input  instr_valid,
    output instr_ready,
    input  opcode, rdst, rsrc, imm, instr_pc, halted
  );
endinterface

// File: rtl/fetch_issue_reg.sv
// rtl/fetch_issue_reg.sv - valid/ready register holding the decoded instruction
// presented to the control unit; fields hold until the next load.
module fetch_issue_reg
  import core_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  instr_fields_t     fields_in,
  input  logic [15:0]       imm_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output instr_fields_t     fields,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      fields <= '0;
      imm    <= '0;
      pc     <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      fields <= fields_in;
      imm    <= imm_in;
      pc     <= pc_in;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch FSM: fetches one/two-word
// instructions, issues them, stops on HLT and handles execute redirects.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              req_q, req_d;
  logic              drain_q, drain_d;
  instr_fields_t     ir_q, ir_d;
  instr_fields_t     rd_fields;

  logic              load, clear, take, accept;
  instr_fields_t     ld_fields;
  logic [15:0]       ld_imm;
  logic [ADDR_W-1:0] ld_pc;

  logic              out_valid;
  instr_fields_t     out_fields;
  logic [15:0]       out_imm;
  logic [ADDR_W-1:0] out_pc;

  assign rd_fields = bus.imem_rdata[OPC_MSB:RSRC_LSB];
  assign take      = req_q & bus.imem_ack;
  assign accept    = out_valid & bus.instr_ready;

  // drain_q marks a request issued before a flush: its data is dropped on ack
  // and the address stays on the old request until then.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drain_d   = drain_q;
    ir_d      = ir_q;
    ir_pc_d   = ir_pc_q;
    load      = 1'b0;
    clear     = 1'b0;
    ld_fields = rd_fields;
    ld_imm    = '0;
    ld_pc     = pc_q;

    if (drain_q) begin
      if (take) drain_d = 1'b0;
    end else begin
      case (state_q)
        FETCH1: begin
          if (take) begin
            ir_d    = rd_fields;
            ir_pc_d = pc_q;
            pc_d    = pc_q + 1'b1;
            if (is_two_word(rd_fields.opcode)) begin
              state_d = FETCH2;
            end else begin
              state_d = ISSUE;
              load    = 1'b1;
            end
          end
        end
        FETCH2: begin
          if (take) begin
            pc_d      = pc_q + 1'b1;
            state_d   = ISSUE;
            load      = 1'b1;
            ld_fields = ir_q;
            ld_imm    = bus.imem_rdata;
            ld_pc     = ir_pc_q;
          end
        end
        ISSUE: begin
          if (accept) begin
            clear   = 1'b1;
            state_d = (out_fields.opcode == OPC_HLT) ? HALT : FETCH1;
          end
        end
        HALT: begin
          state_d = HALT;
        end
      endcase
    end

    // Redirect overrides everything decided above; an accept in this cycle
    // has already completed on the consumer side.
    if (bus.flush) begin
      state_d = FETCH1;
      pc_d    = bus.flush_pc;
      clear   = 1'b1;
      load    = 1'b0;
      drain_d = req_q & ~bus.imem_ack;
    end

    req_d  = drain_d | (state_d == FETCH1) | (state_d == FETCH2);
    addr_d = drain_d ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH1;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      drain_q <= 1'b0;
      ir_q    <= '0;
      ir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      drain_q <= drain_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
    end
  end

  fetch_issue_reg #(
    .ADDR_W (ADDR_W)
  ) u_issue (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .clear     (clear),
    .fields_in (ld_fields),
    .imm_in    (ld_imm),
    .pc_in     (ld_pc),
    .valid     (out_valid),
    .fields    (out_fields),
    .imm       (out_imm),
    .pc        (out_pc)
  );

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = out_valid;
  assign bus.opcode      = out_fields.opcode;
  assign bus.rdst        = out_fields.rdst;
  assign bus.rsrc        = out_fields.rsrc;
  assign bus.imm         = out_imm;
  assign bus.instr_pc    = out_pc;
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench: random programs in a sparse
// memory model, expected issue stream predicted from the ISA rules.
module tb_instr_fetch_unit;

  localparam int          ADDR_W = 20;
  localparam int unsigned AMASK  = (1 << ADDR_W) - 1;
  localparam logic [6:0]  HLT    = 7'b1100001;

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic [19:0] pc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (20'h00000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  logic [15:0] mem[int unsigned];
  int          total = 0;
  int          bad   = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          hold_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int unsigned a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  function automatic bit two_word(input logic [6:0] o);
    return (o == 7'b0100000) || (o == 7'b0110101) || (o == 7'b0100010);
  endfunction

  function automatic logic [15:0] rand_one_word();
    logic [15:0] w = 16'($urandom);
    while (two_word(w[15:9]) || w[15:9] == HLT) w[15:9] = 7'($urandom);
    return w;
  endfunction

  // Walk the program from start: each instruction is one word, or two when
  // its opcode carries an immediate; addresses wrap modulo 2^ADDR_W.
  task automatic predict(input int unsigned start, input int max_n);
    int unsigned p = start & AMASK;
    logic [15:0] w;
    exp_t e;
    for (int n = 0; n < max_n; n++) begin
      w     = mem_rd(p);
      e.opc = w[15:9];
      e.rd  = w[8:6];
      e.rs  = w[5:3];
      e.pc  = p[19:0];
      if (two_word(e.opc)) begin
        e.imm = mem_rd((p + 1) & AMASK);
        p     = (p + 2) & AMASK;
      end else begin
        e.imm = 16'h0000;
        p     = (p + 1) & AMASK;
      end
      exp_q.push_back(e);
      if (e.opc == HLT) break;
    end
  endtask

  task automatic write_prog(input int unsigned start, input int n);
    int unsigned p = start & AMASK;
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = rand_one_word();
      case ($urandom_range(0, 3))
        0: w[15:9] = 7'b0100000;
        1: w[15:9] = ($urandom_range(0, 1) != 0) ? 7'b0110101 : 7'b0100010;
        default: ;
      endcase
      mem[p] = w;
      p = (p + 1) & AMASK;
      if (two_word(w[15:9])) begin
        mem[p] = 16'($urandom);
        p = (p + 1) & AMASK;
      end
    end
    mem[p] = {HLT, 9'($urandom)};
  endtask

  function automatic exp_t cur_out();
    exp_t g;
    g.opc = bus.opcode;
    g.rd  = bus.rdst;
    g.rs  = bus.rsrc;
    g.imm = bus.imm;
    g.pc  = bus.instr_pc;
    return g;
  endfunction

  // Memory responder: random latency per request, one-cycle ack pulse.
  int          cnt = -1;
  bit          last_wait = 1'b0;
  logic [19:0] last_addr;
  always @(negedge clk) begin
    if (last_wait && reset) begin
      check("imem_req_held", bus.imem_req, 1);
      check("imem_addr_stable", bus.imem_addr, last_addr);
    end
    bus.imem_ack = 1'b0;
    last_wait    = 1'b0;
    if (!reset) begin
      cnt = -1;
      bus.imem_rdata = 16'h0000;
    end else if (bus.imem_req) begin
      if (cnt < 0) cnt = $urandom_range(lat_min, lat_max);
      if (cnt == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_rd(bus.imem_addr);
        cnt = -1;
      end else begin
        cnt--;
        last_wait = 1'b1;
        last_addr = bus.imem_addr;
      end
    end
  end

  // Consumer and scoreboard monitor: ready is chosen and the accept judged
  // in one process so both see the same value.
  exp_t mon_g, mon_e;
  always @(negedge clk) begin
    bus.instr_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (reset && bus.instr_valid && bus.instr_ready) begin
      mon_g = cur_out();
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue: got %0h expected none", mon_g);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue", mon_g, mon_e);
      end
    end
  end

  task automatic do_flush(input int unsigned target);
    bus.flush_pc = target[19:0];
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int bound);
    int n = 0;
    while (!bus.halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.halted, 1);
  endtask

  initial begin
    int   n;
    exp_t snap;
    exp_t want;
    int unsigned start;

    bus.flush    = 1'b0;
    bus.flush_pc = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_req",   bus.imem_req, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_fields", cur_out(), 0);
    check("rst_halted", bus.halted, 0);

    // Two one-word instructions then HLT, memory acking every 2nd cycle.
    mem[0] = 16'h0A00;
    mem[1] = 16'h1A40;
    mem[2] = 16'hC200;
    lat_min = 1;
    lat_max = 1;
    predict(0, 64);
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.imem_req && n < 10);
    check("first_req_cycle", n, 1);
    check("first_req_addr", bus.imem_addr, 0);
    wait_halted("halt_a", 200);
    check("sbd_empty_a", exp_q.size(), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req) n++;
    end
    check("halt_no_req", n, 0);
    check("halt_stays", bus.halted, 1);

    // IADD with immediate, issue stalled for 5 cycles.
    mem[32'h40] = 16'h4000;
    mem[32'h41] = 16'h1234;
    mem[32'h42] = 16'hC200;
    hold_ready = 1'b1;
    @(negedge clk);
    predict(32'h40, 64);
    do_flush(32'h40);
    check("flush_unhalt", bus.halted, 0);
    check("flush_req", {bus.imem_req, bus.imem_addr}, {1'b1, 20'h00040});
    n = 0;
    while (!bus.instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("iadd_valid", bus.instr_valid, 1);
    snap = cur_out();
    want = '{opc: 7'b0100000, rd: 3'd0, rs: 3'd0, imm: 16'h1234, pc: 20'h00040};
    check("iadd_fields", snap, want);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {bus.instr_valid, bus.imem_req, cur_out()}, {1'b1, 1'b0, snap});
    end
    hold_ready = 1'b0;
    n = 0;
    while (bus.instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("resume_req", {bus.imem_req, bus.imem_addr}, {1'b1, 20'h00042});
    wait_halted("halt_b", 200);
    check("sbd_empty_b", exp_q.size(), 0);

    // Flush while the request to 0x5 waits; its data must be discarded.
    for (int i = 0; i < 5; i++) mem[i] = rand_one_word();
    mem[5] = 16'hC200;
    write_prog(32'h10, 4);
    lat_min = 3;
    lat_max = 3;
    predict(0, 5);
    do_flush(0);
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == 20'h5) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("req_at_5", {bus.imem_req, bus.imem_addr}, {1'b1, 20'h00005});
    check("sbd_empty_pre", exp_q.size(), 0);
    do_flush(32'h10);
    predict(32'h10, 64);
    n = 0;
    while (bus.imem_req && bus.imem_addr == 20'h5 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("drain_then_target", {bus.imem_req, bus.imem_addr}, {1'b1, 20'h00010});
    wait_halted("halt_c", 400);
    check("sbd_empty_c", exp_q.size(), 0);

    // LDM at the top address, immediate wraps to address 0.
    mem[32'hFFFFF] = {7'b0110101, 9'($urandom)};
    mem[0]         = 16'($urandom);
    mem[1]         = {HLT, 9'($urandom)};
    lat_min = 0;
    lat_max = 2;
    predict(32'hFFFFF, 64);
    do_flush(32'hFFFFF);
    wait_halted("halt_wrap", 200);
    check("sbd_empty_wrap", exp_q.size(), 0);

    // Random programs at random start addresses, some near the wrap point.
    for (int r = 0; r < 6; r++) begin
      start = ($urandom_range(0, 1) != 0) ? (AMASK - $urandom_range(0, 4)) : ($urandom & AMASK);
      lat_min = 0;
      lat_max = $urandom_range(0, 3);
      write_prog(start, $urandom_range(3, 8));
      predict(start, 64);
      do_flush(start);
      wait_halted("halt_rand", 600);
      check("sbd_empty_rand", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
